// File: rtl/seg_display_ctrl_if.sv
// Result-word input and seven-segment output bundle for seg_display_ctrl.
// master drives the pipeline side; slave is the display controller.
interface seg_display_ctrl_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        sw;
  logic [1:0]  sel_out;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output data_in,
    output data_valid,
    output sw,
    output sel_out,
    input  seg,
    input  an
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  sw,
    input  sel_out,
    output seg,
    output an
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Latches the pipeline result word and multiplexes a 16-bit view over a 4-digit
// common-anode seven-segment display, paced by a prescaler tick in the core clock domain.
module seg_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned ALT_SCANS   = 250
) (
  input logic               clk,
  input logic               rst,
  seg_display_ctrl_if.slave bus
);

  localparam int unsigned PreW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ScanW = (ALT_SCANS > 1) ? $clog2(ALT_SCANS) : 1;
  localparam logic [PreW-1:0]  PreLast  = PreW'(REFRESH_DIV - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(ALT_SCANS - 1);

  logic [31:0]      data_q, data_d;
  logic [15:0]      upd_q, upd_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [1:0]       dig_q, dig_d;
  logic             half_q, half_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic        tick;
  logic        scan_end;
  logic [15:0] view;
  logic [3:0]  nibble;

  assign tick     = (pre_q == PreLast);
  assign scan_end = tick && (dig_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      upd_q  <= '0;
      pre_q  <= '0;
      dig_q  <= '0;
      half_q <= 1'b0;
      scan_q <= '0;
      seg_q  <= 7'b1111111;
      an_q   <= 4'b1111;
    end else begin
      data_q <= data_d;
      upd_q  <= upd_d;
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      half_q <= half_d;
      scan_q <= scan_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  always_comb begin
    data_d = data_q;
    upd_d  = upd_q;
    // Freeze drops the strobe entirely: neither the word nor the count moves.
    if (bus.data_valid && !bus.sw) begin
      data_d = bus.data_in;
      upd_d  = upd_q + 16'd1;
    end

    pre_d = tick ? '0 : pre_q + PreW'(1);
    dig_d = tick ? dig_q + 2'd1 : dig_q;

    scan_d = scan_q;
    half_d = half_q;
    // Leaving auto-alternate parks it so that re-entry starts on the lower half.
    if (bus.sel_out != 2'b11) begin
      scan_d = '0;
      half_d = 1'b0;
    end else if (scan_end) begin
      if (scan_q == ScanLast) begin
        scan_d = '0;
        half_d = ~half_q;
      end else begin
        scan_d = scan_q + ScanW'(1);
      end
    end
  end

  always_comb begin
    view = data_q[15:0];
    unique case (bus.sel_out)
      2'b00: view = data_q[15:0];
      2'b01: view = data_q[31:16];
      2'b10: view = upd_q;
      2'b11: view = half_q ? data_q[31:16] : data_q[15:0];
      default: view = data_q[15:0];
    endcase

    nibble = view[{dig_q, 2'b00} +: 4];

    seg_d = 7'b1111111;
    case (nibble)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'b1111111;
    endcase

    an_d = ~(4'b0001 << dig_q);
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl with REFRESH_DIV=4, ALT_SCANS=2.
module tb_seg_display_ctrl;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  seg_display_ctrl_if bus ();

  seg_display_ctrl #(
    .REFRESH_DIV(4),
    .ALT_SCANS  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Samples one full scan; s holds digit 3..0 segments from MSB to LSB.
  task automatic grab_view(output logic [27:0] s, output logic [3:0] seen);
    s    = '0;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: begin s[6:0]   = bus.seg; seen[0] = 1'b1; end
        4'b1101: begin s[13:7]  = bus.seg; seen[1] = 1'b1; end
        4'b1011: begin s[20:14] = bus.seg; seen[2] = 1'b1; end
        4'b0111: begin s[27:21] = bus.seg; seen[3] = 1'b1; end
        default: seen = 4'b0000;
      endcase
    end
  endtask

  task automatic strobe(input logic [31:0] w);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic check_view(input string name, input logic [27:0] exp);
    logic [27:0] s;
    logic [3:0]  seen;
    repeat (2) @(negedge clk);
    grab_view(s, seen);
    chk_cnt++;
    if ({seen, s} !== {4'hF, exp})
      $display("FAIL %s: got seen=%b seg=%h, expected seen=1111 seg=%h", name, seen, s, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    bus.sw = 1'b0;
    bus.sel_out = 2'b00;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({bus.an, bus.seg} !== {4'b1111, 7'b1111111})
      $display("FAIL reset_blank: got an=%b seg=%b, expected an=1111 seg=1111111", bus.an, bus.seg);
    else
      pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] ean;
      @(negedge clk);
      ean = ~(4'b0001 << ((i / 4) % 4));
      chk_cnt++;
      if ({bus.an, bus.seg} !== {ean, 7'b1000000})
        $display("FAIL scan_%0d: got an=%b seg=%b, expected an=%b seg=1000000",
                 i, bus.an, bus.seg, ean);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_capture();
    strobe(32'hDEAD_BEEF);
    bus.sel_out = 2'b00;
    check_view("capture_low", {hex7(4'hB), hex7(4'hE), hex7(4'hE), hex7(4'hF)});
    bus.sel_out = 2'b01;
    check_view("capture_high", {hex7(4'hD), hex7(4'hE), hex7(4'hA), hex7(4'hD)});
  endtask

  task automatic test_freeze();
    bus.sw = 1'b1;
    strobe(32'h1234_5678);
    bus.sel_out = 2'b00;
    check_view("freeze_hold", {hex7(4'hB), hex7(4'hE), hex7(4'hE), hex7(4'hF)});
    bus.sel_out = 2'b10;
    check_view("freeze_count", {hex7(4'h0), hex7(4'h0), hex7(4'h0), hex7(4'h1)});
    bus.sw = 1'b0;
    strobe(32'h1234_5678);
    bus.sel_out = 2'b00;
    check_view("unfreeze_low", {hex7(4'h5), hex7(4'h6), hex7(4'h7), hex7(4'h8)});
    bus.sel_out = 2'b10;
    check_view("unfreeze_count", {hex7(4'h0), hex7(4'h0), hex7(4'h0), hex7(4'h2)});
  endtask

  task automatic test_count_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.data_in = '0;
    bus.data_valid = 1'b1;
    repeat (65535) @(negedge clk);
    bus.data_valid = 1'b0;
    bus.sel_out = 2'b10;
    check_view("count_ffff", {hex7(4'hF), hex7(4'hF), hex7(4'hF), hex7(4'hF)});
    strobe(32'h0);
    check_view("count_wrap", {hex7(4'h0), hex7(4'h0), hex7(4'h0), hex7(4'h0)});
  endtask

  task automatic test_auto_alt();
    rst = 1'b1;
    bus.sel_out = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    bus.data_in = 32'hABCD_0123;
    bus.data_valid = 1'b1;
    // k counts edges since reset release; the k-th sample follows edge k.
    for (int k = 1; k <= 140; k++) begin
      logic        upper;
      logic [15:0] hw;
      logic [3:0]  ean;
      logic [6:0]  eseg;
      int          d;
      @(negedge clk);
      bus.data_valid = 1'b0;
      d = ((k - 1) / 4) % 4;
      upper = (k >= 33 && k <= 64) || (k >= 97 && k <= 100) || (k >= 129);
      hw = upper ? 16'hABCD : 16'h0123;
      ean = ~(4'b0001 << d);
      eseg = (k == 1) ? hex7(4'h0) : hex7(hw[4*d +: 4]);
      chk_cnt++;
      if ({bus.an, bus.seg} !== {ean, eseg})
        $display("FAIL alt_%0d: got an=%b seg=%b, expected an=%b seg=%b",
                 k, bus.an, bus.seg, ean, eseg);
      else
        pass_cnt++;
      if (k == 100) bus.sel_out = 2'b00;
      if (k == 102) bus.sel_out = 2'b11;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    bus.sel_out = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!found) $display("FAIL mid_wait: got no an=1011 within 40 cycles, expected one");
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({bus.an, bus.seg} !== {4'b1111, 7'b1111111})
      $display("FAIL mid_blank: got an=%b seg=%b, expected an=1111 seg=1111111", bus.an, bus.seg);
    else
      pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({bus.an, bus.seg} !== {4'b1110, 7'b1000000})
      $display("FAIL mid_restart: got an=%b seg=%b, expected an=1110 seg=1000000", bus.an, bus.seg);
    else
      pass_cnt++;
    bus.sel_out = 2'b01;
    check_view("mid_discard", {hex7(4'h0), hex7(4'h0), hex7(4'h0), hex7(4'h0)});
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_capture();
    test_freeze();
    test_count_wrap();
    test_auto_alt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Downstream consumer of the pipelined processor's selected result word.
- Latches the 32-bit value on a write-back strobe and time-multiplexes a 16-bit view across a 4-digit common-anode seven-segment display.
- Replaces the separate display clock with a prescaler tick in the single core clock domain.
- Supports freeze (sw), halfword select, update counting, and auto-alternating halves.

Parameters:
- REFRESH_DIV, 50000, core clocks per digit slot. Minimum 2. Benches use 4.
- ALT_SCANS, 250, full 4-digit scans per half in auto-alternate mode. Minimum 1. Benches use 2.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset.
- data_in  in  32  result word from the pipeline.
- data_valid  in  1  one-cycle strobe marking data_in valid.
- sw  in  1  freeze. 1 = ignore data_valid and hold the latched word.
- sel_out  in  2  view select.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  out  4  active-low digit enables. an[0] is the rightmost digit.
- Interface (already decided): one clock; reset is synchronous and active-high (ports named clk and rst).

Behaviour:
- Reset (rst=1 at a rising edge) clears:
  - data_reg=0, upd_cnt=0, pre_cnt=0, dig=0, half=0, scan_cnt=0.
  - seg=7'b1111111 (blank), an=4'b1111 (all off).
- Reset mid-operation aborts the scan and discards the latched word. There is no partial state.
- Capture: at an edge where data_valid=1 and sw=0:
  - data_reg <= data_in.
  - upd_cnt <= upd_cnt+1, a 16-bit counter that wraps FFFF->0000.
- If data_valid=1 and sw=1, the strobe is dropped: no latch and no count.
- Prescaler: pre_cnt counts 0..REFRESH_DIV-1 then wraps to 0.
  - tick=1 for the single cycle where pre_cnt==REFRESH_DIV-1.
- Digit scan: on tick, dig advances 0->1->2->3->0.
  - scan_end = tick && dig==3.
- View word (16 bits), selected by sel_out:
  - 00 -> data_reg[15:0].
  - 01 -> data_reg[31:16].
  - 10 -> upd_cnt.
  - 11 -> half ? data_reg[31:16] : data_reg[15:0].
- Auto-alternate (sel_out=11):
  - scan_cnt increments on scan_end.
  - When scan_cnt==ALT_SCANS-1 and scan_end: scan_cnt<=0 and half toggles.
  - When sel_out!=11, scan_cnt<=0 and half<=0 every cycle. Re-entering mode 11 always starts on the lower half.
- sel_out and sw changes take effect on the next clock. No synchronisation is required; both inputs are in the clk domain.
- Outputs are registered and updated every clock from current state, so latency is 1 cycle:
  - an <= ~(4'b0001 << dig).
  - seg <= hex decode of view[4*dig+3 : 4*dig].
- After reset deasserts, the first edge gives an=1110 and seg = digit 0 of the view.
- Hex decode ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No leading-zero blanking. Exactly one an bit is low at all times outside reset.
- A capture on the same edge as a tick is legal. The new word is visible at the next output update.
- No decimal point is driven.

Test Plan:
- Reset and scan (REFRESH_DIV=4), data_reg=0, sel_out=00:
  - Release rst; sample an each cycle.
  - Required: 1110 ×4, 1101 ×4, 1011 ×4, 0111 ×4, then repeat.
  - seg=1000000 throughout. While rst=1: seg=1111111, an=1111.
- Capture and select: strobe data_in=32'hDEAD_BEEF, sw=0.
  - sel_out=00: digits 0..3 show F,E,E,b (0001110, 0000110, 0000110, 0000011).
  - sel_out=01: digits 0..3 show d,A,E,d.
- Freeze: sw=1, strobe 32'h1234_5678.
  - Display stays DEAD_BEEF and upd_cnt is unchanged.
  - With sw=0, the same strobe latches and sel_out=00 shows 8,7,6,5.
- Update counter wrap: 65535 strobes, then sel_out=10.
  - Display shows F,F,F,F.
  - One more strobe shows 0,0,0,0.
- Auto-alternate (ALT_SCANS=2), data_reg=32'hABCD_0123, sel_out=11:
  - First 2 scans (32 cycles) show 3,2,1,0.
  - Next 2 scans show D,C,b,A, then back to the lower half.
  - Switching to 00 and back to 11 mid-upper-half restarts on the lower half.
- Reset mid-scan: assert rst at dig=2 with data latched.
  - The next edge gives blank outputs.
  - After release: an=1110 and the view shows 0.
